// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//   Serial transmitter with 8N1 framing by default. It takes one byte per
//   TxValid/TxReady handshake and shifts it out on TxD as a start bit, then
//   8 data bits LSB first, then a stop bit. Each bit is exactly CLKS_PER_BIT
//   cycles wide.
//
//   Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
//   between data bit 7 and the stop bit. The frame is then 11 bits.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous reset, active low
//   TxData   in   [7:0] byte to send, sampled only at the accepting edge
//   TxValid  in   TxData is valid
//   TxReady  out  idle and able to accept a byte
//   TxD      out  serial line, idles high, driven straight from a flop
//   TxBusy   out  a frame is in progress (inverse of TxReady)
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    output logic       TxD,
    output logic       TxBusy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q,   idx_d;
    logic [CW-1:0] baud_q,  baud_d;
    logic          txd_q,   txd_d;
    logic          bit_done;
`ifdef UART_TX_PARITY_EN
    // Parity is captured at acceptance because the shift register is
    // consumed while the data bits go out.
    logic          par_q,   par_d;
`endif

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        baud_d   = baud_q;
        txd_d    = txd_q;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        bit_done = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (TxValid) begin
                    shift_d = TxData;
                    txd_d   = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^TxData;
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = S_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        // The next bit to present is shift_q[1]; loading TxD
                        // from it keeps TxD registered with no extra cycle.
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    baud_d  = '0;
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            baud_q  <= '0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            baud_q  <= baud_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TxD     = txd_q;
    assign TxReady = (state_q == S_IDLE);
    assign TxBusy  = ~TxReady;

endmodule
